// File: rtl/fuzz_seq_pkg.sv
// Shared types and constants for the fuzz stimulus sequencer.
// Holds the FSM state encoding, LCG constants and MISR polynomial.
package fuzz_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_APPLY,
    ST_CAPTURE,
    ST_DONE
  } seq_state_e;

  localparam logic [31:0] LCG_MUL   = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC   = 32'h00003039;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

  function automatic logic [31:0] lcg_step(input logic [31:0] x);
    return x * LCG_MUL + LCG_INC;
  endfunction

endpackage

// File: rtl/fuzz_misr.sv
// Folds out_flat into 32 bits and advances the MISR by one step.
// Purely combinational; the caller decides when to register sig_nxt.
module fuzz_misr #(
  parameter int OUT_W = 159
) (
  input  logic [31:0]      sig,
  input  logic [OUT_W-1:0] out_flat,
  output logic [31:0]      sig_nxt
);
  import fuzz_seq_pkg::*;

  logic [31:0] fold;

  // Bit b lands in fold[b%32]; missing top bits of the last slice act as zero padding.
  always_comb begin
    fold = '0;
    for (int b = 0; b < OUT_W; b++) begin
      fold[b % 32] = fold[b % 32] ^ out_flat[b];
    end
    sig_nxt = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ fold;
  end

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// Expands a seed into IN_W-bit vectors, pulses dut_ce once per vector and MISR-compresses out_flat.
// Period chunks+2 clocks per vector; no backpressure, stop aborts to IDLE.
module fuzz_stim_sequencer #(
  parameter int          IN_W    = 136,
  parameter int          OUT_W   = 159,
  parameter logic [31:0] LCG_MUL = 32'h41C64E6D,
  parameter logic [31:0] LCG_INC = 32'h00003039,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_vec,
  output logic [IN_W-1:0]  in_flat,
  output logic             dut_ce,
  input  logic [OUT_W-1:0] out_flat,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_idx,
  output logic [31:0]      signature
);
  import fuzz_seq_pkg::*;

  localparam int CHUNKS  = (IN_W + 31) / 32;
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  seq_state_e         state, state_nxt;
  logic [31:0]        rng, rng_nxt;
  logic [CHUNK_W-1:0] chunk;
  logic [CNT_W-1:0]   budget;
  logic [31:0]        sig_nxt;
  logic               start_ok, last_chunk, last_vec;

  assign rng_nxt    = rng * LCG_MUL + LCG_INC;
  assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
  assign last_chunk = (chunk == CHUNK_W'(CHUNKS - 1));
  assign last_vec   = ((vec_idx + CNT_W'(1)) == budget);

  fuzz_misr #(.OUT_W(OUT_W)) u_misr (
    .sig      (signature),
    .out_flat (out_flat),
    .sig_nxt  (sig_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state_nxt = (num_vec == '0) ? ST_DONE : ST_GEN;
        ST_GEN:           if (last_chunk) state_nxt = ST_APPLY;
        ST_APPLY:         state_nxt = ST_CAPTURE;
        ST_CAPTURE:       state_nxt = last_vec ? ST_DONE : ST_GEN;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  // dut_ce is masked by stop so an aborted APPLY cycle never clocks the DUT.
  always_comb begin
    dut_ce = (state == ST_APPLY) && !stop;
    busy   = (state == ST_GEN) || (state == ST_APPLY) || (state == ST_CAPTURE);
    done   = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rng       <= '0;
      chunk     <= '0;
      budget    <= '0;
      vec_idx   <= '0;
      signature <= '0;
      in_flat   <= '0;
    end else if (!stop) begin
      if (start_ok) begin
        rng       <= seed;
        budget    <= num_vec;
        vec_idx   <= '0;
        signature <= '0;
        chunk     <= '0;
      end else begin
        case (state)
          ST_GEN: begin
            rng   <= rng_nxt;
            chunk <= last_chunk ? '0 : chunk + CHUNK_W'(1);
            // Only bits inside IN_W exist, so the last chunk keeps the low bits of rng_nxt.
            for (int b = 0; b < IN_W; b++) begin
              if (chunk == CHUNK_W'(b / 32)) in_flat[b] <= rng_nxt[b % 32];
            end
          end
          ST_CAPTURE: begin
            signature <= sig_nxt;
            vec_idx   <= vec_idx + CNT_W'(1);
            chunk     <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Directed bench for fuzz_stim_sequencer with an LCG/MISR reference model.
module tb_fuzz_stim_sequencer;

  logic         clk = 1'b0;
  logic         rst_n, start, stop;
  logic [31:0]  seed, num_vec;
  logic [135:0] in_flat;
  logic         dut_ce, busy, done;
  logic [158:0] out_flat;
  logic [31:0]  vec_idx, signature;

  int tests = 0;
  int fails = 0;
  int out_mode = 0;
  int cyc = 0;
  int ce_cnt = 0;
  int ce_cyc[64];

  always #5 clk = ~clk;

  fuzz_stim_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .seed      (seed),
    .num_vec   (num_vec),
    .in_flat   (in_flat),
    .dut_ce    (dut_ce),
    .out_flat  (out_flat),
    .busy      (busy),
    .done      (done),
    .vec_idx   (vec_idx),
    .signature (signature)
  );

  // Stand-in DUT: mode 0 derives the output from the applied vector, 1/2 force constants.
  always_comb begin
    out_flat = {in_flat[22:0], in_flat};
    if (out_mode == 1) out_flat = '0;
    if (out_mode == 2) out_flat = 159'h1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut_ce) begin
      if (ce_cnt < 64) ce_cyc[ce_cnt] <= cyc;
      ce_cnt <= ce_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] n);
    seed    = s;
    num_vec = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int k = 0;
    while (!done && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, done, 1);
  endtask

  function automatic logic [31:0] m_lcg(input logic [31:0] x);
    return x * 32'h41C64E6D + 32'h00003039;
  endfunction

  task automatic model(input logic [31:0] s, input int n, input int mode,
                       output logic [135:0] vec, output logic [31:0] sig);
    logic [31:0]  r;
    logic [159:0] pad;
    logic [31:0]  fold;
    r   = s;
    sig = '0;
    vec = '0;
    for (int v = 0; v < n; v++) begin
      for (int c = 0; c < 5; c++) begin
        r = m_lcg(r);
        if (c < 4) vec[32*c +: 32] = r;
        else       vec[135:128]    = r[7:0];
      end
      if (mode == 1)      pad = '0;
      else if (mode == 2) pad = 160'h1;
      else                pad = {1'b0, vec[22:0], vec};
      fold = '0;
      for (int k = 0; k < 5; k++) fold = fold ^ pad[32*k +: 32];
      sig = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C11DB7 : 32'h0) ^ fold;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    logic [135:0] m_vec;
    logic [31:0]  m_sig;
    logic         ce_at[10];
    logic         done_at[10];
    int           n0;
    int           k;

    rst_n = 1'b1; start = 1'b0; stop = 1'b0; seed = '0; num_vec = '0;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_in_flat", in_flat, 0);
    chk("rst_dut_ce", dut_ce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec_idx", vec_idx, 0);
    chk("rst_signature", signature, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: seed 0, one vector
    out_mode = 0;
    n0 = ce_cnt;
    pulse_start(32'h0, 32'd1);
    chk("t1_busy", busy, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      ce_at[i]   = dut_ce;
      done_at[i] = done;
    end
    chk("t1_ce_before", ce_at[4], 0);
    chk("t1_ce_6th", ce_at[5], 1);
    chk("t1_ce_after", ce_at[6], 0);
    chk("t1_done_early", done_at[6], 0);
    chk("t1_done_8th", done_at[7], 1);
    chk("t1_chunk0", in_flat[31:0], 32'h00003039);
    chk("t1_chunk1", in_flat[63:32], 32'hD3DC167E);
    model(32'h0, 1, 0, m_vec, m_sig);
    chk("t1_in_flat", in_flat, m_vec);
    chk("t1_signature", signature, m_sig);
    chk("t1_vec_idx", vec_idx, 1);
    chk("t1_ce_count", ce_cnt - n0, 1);

    // 2: zero budget goes straight to DONE
    n0 = ce_cnt;
    pulse_start(32'h5, 32'd0);
    chk("t2_done", done, 1);
    chk("t2_signature", signature, 0);
    chk("t2_vec_idx", vec_idx, 0);
    repeat (10) tick();
    chk("t2_no_ce", ce_cnt - n0, 0);

    // 3: zero output, three vectors; second start while busy must be ignored
    out_mode = 1;
    n0 = ce_cnt;
    pulse_start(32'h12345678, 32'd3);
    repeat (3) tick();
    pulse_start(32'hFFFF0000, 32'd0);
    chk("t3_busy_ignore", busy, 1);
    wait_done("t3_done", 100);
    chk("t3_signature", signature, 0);
    chk("t3_vec_idx", vec_idx, 3);
    chk("t3_ce_count", ce_cnt - n0, 3);
    chk("t3_gap1", ce_cyc[n0+1] - ce_cyc[n0], 7);
    chk("t3_gap2", ce_cyc[n0+2] - ce_cyc[n0+1], 7);

    // 4: output = 1 for two vectors
    out_mode = 2;
    pulse_start(32'hCAFEBABE, 32'd2);
    wait_done("t4_done", 100);
    chk("t4_signature", signature, 32'h00000003);
    chk("t4_vec_idx", vec_idx, 2);

    // 5: stop during the second GEN phase
    out_mode = 0;
    n0 = ce_cnt;
    pulse_start(32'h00C0FFEE, 32'd4);
    repeat (9) tick();
    chk("t5_busy_pre", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_vec_idx", vec_idx, 1);
    repeat (30) tick();
    chk("t5_ce_count", ce_cnt - n0, 1);
    pulse_start(32'h13572468, 32'd1);
    wait_done("t5_restart_done", 100);
    model(32'h13572468, 1, 0, m_vec, m_sig);
    chk("t5_restart_sig", signature, m_sig);
    chk("t5_restart_idx", vec_idx, 1);

    // 6: async reset during APPLY, then an identical rerun
    pulse_start(32'h0BADF00D, 32'd2);
    k = 0;
    while (!dut_ce && k < 20) begin
      tick();
      k++;
    end
    chk("t6_in_apply", dut_ce, 1);
    n0 = ce_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_in_flat", in_flat, 0);
    chk("t6_rst_dut_ce", dut_ce, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_vec_idx", vec_idx, 0);
    chk("t6_rst_signature", signature, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_no_ce", ce_cnt - n0, 0);
    pulse_start(32'h0BADF00D, 32'd2);
    wait_done("t6_done", 100);
    model(32'h0BADF00D, 2, 0, m_vec, m_sig);
    chk("t6_signature", signature, m_sig);
    chk("t6_in_flat", in_flat, m_vec);
    chk("t6_vec_idx", vec_idx, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
